add_tree_sched: RTL and testbench
=================================

Name: add_tree_sched

Overview:
- Shares one 4-input, 2-stage pipelined adder tree (add2_2 datapath) between pNUM_REQ requesters.
- Round-robin arbitration picks one operand group per cycle and drives the tree enable and operands.
- Tracks in-flight tokens (valid + requester ID) alongside the tree's pipeline and returns each sum tagged with its requester ID.
- Output backpressure freezes the whole tree through its enable. Sits between conv partial-sum producers and the accumulation stage.

Parameters:
- pDATA_W, 8, operand width; sum width is 2*pDATA_W.
- pNUM_REQ, 4, number of requesters (>=2).
- lpID_W (local), $clog2(pNUM_REQ), requester ID width.

Ports:
- iclk  in  1  clock; all logic on rising edge.
- irst_n  in  1  asynchronous active-low reset.
- ireq_valid  in  pNUM_REQ  per-requester operand group valid.
- ireq_data  in  [pNUM_REQ][4][pDATA_W]  per-requester 4 operands.
- oreq_ready  out  pNUM_REQ  one-hot accept; a transfer occurs when valid&ready.
- oadd_en  out  1  tree enable (drives tree ien).
- oadd_data  out  [4][pDATA_W]  operands to the tree (drives tree idata).
- iadd_sum  in  2*pDATA_W  tree output (tree odata).
- ores_valid  out  1  result valid.
- ires_ready  in  1  downstream ready.
- ores_id  out  lpID_W  requester ID of the result.
- ores_data  out  2*pDATA_W  result; combinational pass-through of iadd_sum.

Behaviour:
- Tree model: the tree advances only on edges with oadd_en=1. A group presented at enabled edge E0 appears on iadd_sum after enabled edge E1 (2 enabled edges). Tree arithmetic is ((d0+d1) mod 2^W)+((d2+d3) mod 2^W); the scheduler is width-agnostic and passes the sum through unchanged.
- Token pipe: tag0 and tag1 each hold {valid, id}. On each enabled edge: tag1<=tag0; tag0<={issue, grant_id}.
- Outputs: ores_valid=tag1.valid; ores_id=tag1.id; ores_data=iadd_sum.
- stall = ores_valid & ~ires_ready.
- oadd_en = ~stall & (any ireq_valid | tag0.valid | tag1.valid). An idle, empty pipe does not enable the tree.
- Arbiter: round-robin pointer rr_ptr. The grant goes to the first valid requester at or after rr_ptr, modulo pNUM_REQ.
  - issue = any valid & ~stall.
  - oreq_ready = one-hot(grant) when issue, else 0.
  - oadd_data = ireq_data[grant] when issue, else 0.
  - On issue, rr_ptr <= grant+1, wrapping pNUM_REQ-1 -> 0. rr_ptr is unchanged otherwise.
- Throughput: 1 group/cycle sustained. Latency from issue edge to ores_valid is 2 cycles with no stall.
- Stall: tags, rr_ptr and the tree all freeze; no oreq_ready is asserted. ores_* hold stable until ires_ready=1. No result is lost or duplicated.
- A result is consumed on the edge where ores_valid&ires_ready. In that same cycle a new issue is allowed (no bubble).
- Bubbles: with no request and tokens still in flight, the tree is enabled with tag0.valid=0 so the pipe drains. Bubbles never produce ores_valid.
- ireq_valid deasserting before acceptance is not supported; requesters hold data until ready.
- Reset (async assert, any time):
  - tags cleared; in-flight results discarded.
  - rr_ptr=0.
  - oadd_en=0, oreq_ready=0, ores_valid=0, ores_id=0, oadd_data=0.
  - ores_data follows iadd_sum (not reset).
  - Operation resumes on the first edge after deassertion.

Test Plan:
- Single request: req1 valid with {1,2,3,4}, ires_ready=1 -> oreq_ready=4'b0010 at cycle 0; ores_valid at cycle 2 with ores_id=1, ores_data=10; oadd_en low after drain.
- All 4 requesters valid continuously -> grants cycle 0,1,2,3,0,...; results every cycle with ids 0,1,2,3 in order; no bubbles.
- Backpressure: 3 back-to-back issues, ires_ready=0 for 4 cycles from the first result -> oadd_en=0 and oreq_ready=0 during the stall; ores_data/ores_id stable; all 3 results delivered in order once ready.
- Overflow wrap, pDATA_W=8: operands {200,100,255,1} -> ores_data=44 (44+0).
- Sparse and pointer wrap: only req3 then req0 valid -> grant 3 then 0, rr_ptr wraps to 0 then 1; a bubble cycle between issues yields no spurious ores_valid.
- Reset mid-flight: assert irst_n=0 with 2 tokens in flight -> ores_valid=0 immediately; after release, a first request to req2 is granted and its result alone appears; stale results are never output.

Source files
------------

// File: rtl/add_tree_sched_if.sv
// rtl/add_tree_sched_if.sv - request, adder-tree and result signals of the shared add-tree scheduler
interface add_tree_sched_if #(
    parameter int pDATA_W  = 8,
    parameter int pNUM_REQ = 4
);
    localparam int lpID_W = $clog2(pNUM_REQ);

    logic [pNUM_REQ-1:0]                   ireq_valid;
    logic [pNUM_REQ-1:0][3:0][pDATA_W-1:0] ireq_data;
    logic [pNUM_REQ-1:0]                   oreq_ready;
    logic                                  oadd_en;
    logic [3:0][pDATA_W-1:0]               oadd_data;
    logic [2*pDATA_W-1:0]                  iadd_sum;
    logic                                  ores_valid;
    logic                                  ires_ready;
    logic [lpID_W-1:0]                     ores_id;
    logic [2*pDATA_W-1:0]                  ores_data;

    modport master (
        input  ireq_valid, ireq_data, iadd_sum, ires_ready,
        output oreq_ready, oadd_en, oadd_data, ores_valid, ores_id, ores_data
    );

    modport slave (
        output ireq_valid, ireq_data, iadd_sum, ires_ready,
        input  oreq_ready, oadd_en, oadd_data, ores_valid, ores_id, ores_data
    );
endinterface

// File: rtl/add_tree_sched.sv
// rtl/add_tree_sched.sv - round-robin scheduler sharing one 2-stage 4-input adder tree among requesters
module add_tree_sched #(
    parameter int pDATA_W  = 8,
    parameter int pNUM_REQ = 4
) (
    input  logic              iclk,
    input  logic              irst_n,
    add_tree_sched_if.master  bus
);
    localparam int lpID_W = $clog2(pNUM_REQ);

    logic [lpID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic              tag0_v_q, tag1_v_q;
    logic [lpID_W-1:0] tag0_id_q, tag1_id_q;

    logic              any_valid, stall, issue, add_en, found;
    logic [lpID_W-1:0] grant_id, cand;

    // First valid requester at or after the pointer, wrapping modulo pNUM_REQ.
    always_comb begin
        grant_id = rr_ptr_q;
        found    = 1'b0;
        cand     = '0;
        for (int i = 0; i < pNUM_REQ; i++) begin
            if (int'(rr_ptr_q) + i >= pNUM_REQ)
                cand = lpID_W'(int'(rr_ptr_q) + i - pNUM_REQ);
            else
                cand = lpID_W'(int'(rr_ptr_q) + i);
            if (!found && bus.ireq_valid[cand]) begin
                found    = 1'b1;
                grant_id = cand;
            end
        end
    end

    assign any_valid = |bus.ireq_valid;
    assign stall     = tag1_v_q & ~bus.ires_ready;
    // Reset gates the combinational handshake so nothing is accepted while held in reset.
    assign issue     = irst_n & any_valid & ~stall;
    assign add_en    = irst_n & ~stall & (any_valid | tag0_v_q | tag1_v_q);
    assign rr_ptr_d  = (grant_id == lpID_W'(pNUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        bus.oreq_ready = '0;
        bus.oadd_data  = '0;
        if (issue) begin
            bus.oreq_ready[grant_id] = 1'b1;
            bus.oadd_data            = bus.ireq_data[grant_id];
        end
    end

    assign bus.oadd_en    = add_en;
    assign bus.ores_valid = tag1_v_q;
    assign bus.ores_id    = tag1_id_q;
    assign bus.ores_data  = bus.iadd_sum;

    // Tags shadow the tree's two stages and advance only when the tree does.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            rr_ptr_q  <= '0;
            tag0_v_q  <= 1'b0;
            tag1_v_q  <= 1'b0;
            tag0_id_q <= '0;
            tag1_id_q <= '0;
        end else if (add_en) begin
            tag1_v_q  <= tag0_v_q;
            tag1_id_q <= tag0_id_q;
            tag0_v_q  <= issue;
            tag0_id_q <= grant_id;
            if (issue)
                rr_ptr_q <= rr_ptr_d;
        end
    end
endmodule

// File: tb/tb_add_tree_sched.sv
// tb/tb_add_tree_sched.sv - scoreboard bench for add_tree_sched with a behavioural adder-tree model
module tb_add_tree_sched;
    localparam int W = 8;
    localparam int N = 4;

    typedef logic [3:0][W-1:0] grp_t;
    typedef struct {
        int id;
        int sum;
        int cyc;
        int st;
    } exp_t;

    logic iclk   = 1'b0;
    logic irst_n = 1'b0;
    always #5 iclk = ~iclk;

    add_tree_sched_if #(.pDATA_W(W), .pNUM_REQ(N)) bus ();

    add_tree_sched #(.pDATA_W(W), .pNUM_REQ(N)) dut (
        .iclk   (iclk),
        .irst_n (irst_n),
        .bus    (bus)
    );

    // Shared tree: two enabled edges from operands to sum, each pair wrapping at W bits.
    logic [2*W-1:0] t_s1 = '0;
    logic [2*W-1:0] t_s2 = '0;
    logic [W-1:0]   pa, pb;
    assign pa = bus.oadd_data[0] + bus.oadd_data[1];
    assign pb = bus.oadd_data[2] + bus.oadd_data[3];
    always @(posedge iclk) begin
        if (bus.oadd_en) begin
            t_s1 <= {{W{1'b0}}, pa} + {{W{1'b0}}, pb};
            t_s2 <= t_s1;
        end
    end
    assign bus.iadd_sum = t_s2;

    exp_t         sb[$];
    grp_t         pend[N][$];
    logic [N-1:0] cur_v;
    grp_t         cur_d[N];
    int           n_chk = 0, n_pass = 0, cyc = 0, stall_cnt = 0, ptr = 0;

    always @(posedge iclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic int ref_sum(input grp_t g);
        return ((int'(g[0]) + int'(g[1])) % 256) + ((int'(g[2]) + int'(g[3])) % 256);
    endfunction

    function automatic grp_t rand_grp();
        return grp_t'($urandom);
    endfunction

    task automatic reset_checks();
        chk("rst_oreq_ready", bus.oreq_ready, '0);
        chk("rst_oadd_en",    bus.oadd_en,    '0);
        chk("rst_ores_valid", bus.ores_valid, '0);
        chk("rst_ores_id",    bus.ores_id,    '0);
        chk("rst_oadd_data",  bus.oadd_data,  '0);
        chk("rst_ores_data",  bus.ores_data,  t_s2);
    endtask

    // One cycle: present pending groups, then check arbitration against the round-robin model.
    task automatic step(input bit rdy);
        int           g;
        logic [N-1:0] exp_rdy;
        grp_t         exp_dat;
        bit           stall, any;
        @(negedge iclk);
        for (int r = 0; r < N; r++) begin
            if (!cur_v[r] && pend[r].size() > 0) begin
                cur_d[r] = pend[r].pop_front();
                cur_v[r] = 1'b1;
            end
            bus.ireq_data[r] = cur_d[r];
        end
        bus.ireq_valid = cur_v;
        bus.ires_ready = rdy;
        #1;
        if (!irst_n) return;
        stall = bus.ores_valid && !rdy;
        any   = |cur_v;
        g     = -1;
        for (int k = 0; k < N; k++)
            if (g < 0 && cur_v[(ptr + k) % N]) g = (ptr + k) % N;
        exp_rdy = '0;
        exp_dat = '0;
        if (any && !stall) begin
            exp_rdy[g] = 1'b1;
            exp_dat    = cur_d[g];
        end
        chk("oreq_ready", bus.oreq_ready, exp_rdy);
        chk("oadd_data",  bus.oadd_data,  exp_dat);
        chk("oadd_en",    bus.oadd_en,    !stall && (any || sb.size() > 0));
        if (any && !stall) begin
            sb.push_back('{g, ref_sum(cur_d[g]), cyc, stall_cnt});
            ptr      = (g + 1) % N;
            cur_v[g] = 1'b0;
        end
    endtask

    // Monitor: pops on every consumed result, checks hold stability while stalled.
    bit             prev_stall = 0;
    logic [1:0]     prev_id;
    logic [2*W-1:0] prev_data;
    exp_t           e;
    always @(negedge iclk) begin
        #2;
        if (!irst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", bus.ores_valid, 1'b1);
                chk("hold_id",    bus.ores_id,    prev_id);
                chk("hold_data",  bus.ores_data,  prev_data);
            end
            if (bus.ores_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", bus.ores_valid, 1'b0);
                end else if (bus.ires_ready) begin
                    e = sb.pop_front();
                    chk("res_id",      bus.ores_id,   e.id);
                    chk("res_data",    bus.ores_data, e.sum);
                    chk("res_latency", cyc - e.cyc,   2 + stall_cnt - e.st);
                end else begin
                    stall_cnt++;
                end
            end
            prev_stall = bus.ores_valid && !bus.ires_ready;
            prev_id    = bus.ores_id;
            prev_data  = bus.ores_data;
        end
    end

    initial begin
        grp_t g2;
        cur_v          = '0;
        for (int r = 0; r < N; r++) cur_d[r] = '0;
        bus.ireq_data  = '0;
        bus.ires_ready = 1'b1;
        bus.ireq_valid = 4'b0001;
        bus.ireq_data[0] = {8'd9, 8'd8, 8'd7, 8'd6};
        repeat (2) @(negedge iclk);
        #1 reset_checks();
        bus.ireq_valid = '0;
        @(posedge iclk);
        #2 irst_n = 1'b1;

        // single request on req1
        pend[1].push_back({8'd4, 8'd3, 8'd2, 8'd1});
        repeat (6) step(1'b1);

        // all requesters busy
        for (int r = 0; r < N; r++) repeat (3) pend[r].push_back(rand_grp());
        repeat (16) step(1'b1);

        // backpressure from the first result
        for (int r = 0; r < 3; r++) pend[r].push_back(rand_grp());
        step(1'b1); step(1'b1);
        repeat (4) step(1'b0);
        repeat (8) step(1'b1);

        // per-pair wrap
        pend[2].push_back({8'd1, 8'd255, 8'd100, 8'd200});
        repeat (5) step(1'b1);

        // sparse with a bubble and pointer wrap
        pend[3].push_back(rand_grp());
        repeat (3) step(1'b1);
        pend[0].push_back(rand_grp());
        repeat (5) step(1'b1);

        // reset with two tokens in flight
        pend[0].push_back(rand_grp());
        pend[1].push_back(rand_grp());
        repeat (2) step(1'b1);
        @(negedge iclk);
        irst_n = 1'b0;
        g2 = rand_grp();
        cur_v = '0;
        cur_v[2] = 1'b1;
        cur_d[2] = g2;
        bus.ireq_valid = cur_v;
        bus.ireq_data[2] = g2;
        #1 reset_checks();
        sb.delete();
        ptr = 0;
        for (int r = 0; r < N; r++) pend[r].delete();
        @(posedge iclk);
        #2 irst_n = 1'b1;
        repeat (6) step(1'b1);

        // random traffic and backpressure
        repeat (400) begin
            for (int r = 0; r < N; r++)
                if (pend[r].size() == 0 && $urandom_range(0, 99) < 45)
                    pend[r].push_back(rand_grp());
            step($urandom_range(0, 99) < 70);
        end
        repeat (12) step(1'b1);
        chk("all_results_delivered", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
